// File: rtl/insn_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one read per cycle to a 1-cycle-latency memory,
// buffers responses in a small FIFO and presents {pc, insn} to decode via valid/ready.
module insn_fetch_ctrl #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc_out,
    input  logic [DATA_W-1:0] insn_in,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_insn,
    output logic              busy
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0] buf_pc   [FIFO_DEPTH];
    logic [DATA_W-1:0] buf_insn [FIFO_DEPTH];

    logic              pop_c;
    logic              push_c;
    logic              issue_c;
    logic [PTR_W-1:0]  rd_ptr_c;
    logic [PTR_W-1:0]  wr_ptr_c;
    logic [CNT_W-1:0]  count_c;
    state_t            state_c;
    logic [ADDR_W-1:0] head_pc_c;
    logic [DATA_W-1:0] head_insn_c;

    // Issue only if the buffer can still absorb every outstanding response.
    assign pop_c   = if_valid & if_ready;
    assign push_c  = inflight & ~redirect;
    assign issue_c = (state == RUN) & ~redirect &
                     ((OCC_W'(count) + OCC_W'(inflight)) < (OCC_W'(FIFO_DEPTH) + OCC_W'(pop_c)));

    assign state_c  = en ? RUN : IDLE;
    assign rd_ptr_c = redirect ? '0 : rd_ptr + PTR_W'(pop_c);
    assign wr_ptr_c = redirect ? '0 : wr_ptr + PTR_W'(push_c);
    assign count_c  = redirect ? '0 : count + CNT_W'(push_c) - CNT_W'(pop_c);

    // Next head, bypassing an entry that is being written into the head slot this cycle.
    always_comb begin
        head_pc_c   = buf_pc[rd_ptr_c];
        head_insn_c = buf_insn[rd_ptr_c];
        if (push_c && (wr_ptr == rd_ptr_c)) begin
            head_pc_c   = inflight_pc;
            head_insn_c = insn_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc_out      <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            if_valid    <= 1'b0;
            if_pc       <= '0;
            if_insn     <= '0;
            busy        <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                buf_pc[i]   <= '0;
                buf_insn[i] <= '0;
            end
        end else begin
            state    <= state_c;
            inflight <= issue_c;
            if (issue_c) begin
                inflight_pc <= pc_out;
                pc_out      <= pc_out + ADDR_W'(1);
            end else if (redirect) begin
                pc_out <= redirect_pc;
            end
            if (push_c) begin
                buf_pc[wr_ptr]   <= inflight_pc;
                buf_insn[wr_ptr] <= insn_in;
            end
            count    <= count_c;
            rd_ptr   <= rd_ptr_c;
            wr_ptr   <= wr_ptr_c;
            if_valid <= (count_c != '0);
            if_pc    <= head_pc_c;
            if_insn  <= head_insn_c;
            busy     <= (state_c == RUN) | issue_c | (count_c != '0);
        end
    end

    // The issue rule must never let a response arrive with nowhere to go.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push_c && !pop_c && (count == CNT_W'(FIFO_DEPTH))))
                else $error("fetch buffer overflow");
        end
    end

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// Directed bench for insn_fetch_ctrl; memory returns 0x100 + index one cycle after sampling.
module tb_insn_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        redirect;
    logic [9:0]  redirect_pc;
    logic [9:0]  pc_out;
    logic [31:0] insn_in = '0;
    logic        if_valid;
    logic        if_ready;
    logic [9:0]  if_pc;
    logic [31:0] if_insn;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    insn_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc_out      (pc_out),
        .insn_in     (insn_in),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_insn     (if_insn),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Registered instruction memory, mem[i] = i + 0x100.
    always @(posedge clk) insn_in <= 32'h100 + 32'(pc_out);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_head(input string tag, input int pc);
        check({tag, "_valid"}, 32'(if_valid), 32'd1);
        check({tag, "_pc"}, 32'(if_pc), 32'(pc));
        check({tag, "_insn"}, if_insn, 32'h100 + 32'(pc));
    endtask

    initial begin
        int wrap_pcs [4];
        wrap_pcs = '{1022, 1023, 0, 1};
        rst = 1'b1; en = 1'b0; redirect = 1'b0; redirect_pc = '0; if_ready = 1'b0;

        // T1 reset
        step(); step();
        check("rst_pc", 32'(pc_out), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_if_pc", 32'(if_pc), 32'd0);
        rst = 1'b0;
        step(); step();
        check("idle_pc", 32'(pc_out), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // T2 straight line
        en = 1'b1; if_ready = 1'b1;
        step();
        check("t2_c1_valid", 32'(if_valid), 32'd0);
        check("t2_c1_busy", 32'(busy), 32'd1);
        step();
        check("t2_c2_valid", 32'(if_valid), 32'd0);
        check("t2_c2_pc_out", 32'(pc_out), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            check_head("t2_stream", i);
        end

        // T3 back-pressure from pc 0
        rst = 1'b1;
        step();
        rst = 1'b0; if_ready = 1'b0;
        repeat (6) step();
        check_head("t3_stall", 0);
        check("t3_pc_frozen", 32'(pc_out), 32'd2);
        if_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_head("t3_release", i);
        end

        // T4 redirect while head pc 4 is stalled
        step();
        check_head("t4_head4", 4);
        if_ready = 1'b0;
        step();
        check_head("t4_hold4", 4);
        check("t4_pc_out", 32'(pc_out), 32'd6);
        redirect = 1'b1; redirect_pc = 10'd100;
        step();
        check("t4_flush_valid", 32'(if_valid), 32'd0);
        check("t4_redir_pc_out", 32'(pc_out), 32'd100);
        redirect = 1'b0; if_ready = 1'b1;
        step();
        check("t4_gap_valid", 32'(if_valid), 32'd0);
        for (int i = 100; i <= 102; i++) begin
            step();
            check_head("t4_after", i);
        end

        // T5 wrap around the top of the index space
        redirect = 1'b1; redirect_pc = 10'd1022;
        step();
        check("t5_flush_valid", 32'(if_valid), 32'd0);
        redirect = 1'b0;
        step();
        check("t5_gap_valid", 32'(if_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_head("t5_wrap", wrap_pcs[i]);
        end

        // T6 en drop and resume, then reset mid-stream
        for (int i = 2; i <= 7; i++) begin
            step();
            check_head("t6_run", i);
        end
        en = 1'b0;
        step();
        check_head("t6_drain8", 8);
        step();
        check_head("t6_drain9", 9);
        check("t6_pc_hold", 32'(pc_out), 32'd10);
        step();
        check("t6_empty_valid", 32'(if_valid), 32'd0);
        check("t6_empty_busy", 32'(busy), 32'd0);
        step();
        check("t6_idle_pc", 32'(pc_out), 32'd10);
        en = 1'b1;
        step();
        check("t6_resume_busy", 32'(busy), 32'd1);
        check("t6_resume_valid0", 32'(if_valid), 32'd0);
        step();
        check("t6_resume_pc_out", 32'(pc_out), 32'd11);
        step();
        check_head("t6_resume", 10);
        rst = 1'b1;
        step();
        check("t6_rst_pc", 32'(pc_out), 32'd0);
        check("t6_rst_valid", 32'(if_valid), 32'd0);
        check("t6_rst_if_pc", 32'(if_pc), 32'd0);
        check("t6_rst_if_insn", if_insn, 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0; en = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
